// File: rtl/sdram_probe_capture.sv
// Trigger-based capture of SDRAM bus probes into a circular block-RAM buffer.
// Holds P pre-trigger samples, the trigger sample and DEPTH-1-P post-trigger samples.
module sdram_probe_capture #(
  parameter int DATA_W = 33,
  parameter int DEPTH  = 1024,
  parameter int AW     = $clog2(DEPTH)
) (
  input  logic              sys_clk,
  input  logic              sys_resetn,
  input  logic [DATA_W-1:0] probe_i,
  input  logic              arm_i,
  input  logic              abort_i,
  input  logic              force_trig_i,
  input  logic [DATA_W-1:0] trig_mask_i,
  input  logic [DATA_W-1:0] trig_value_i,
  input  logic [DATA_W-1:0] edge_mask_i,
  input  logic [AW-1:0]     pre_trig_i,
  input  logic [AW-1:0]     rd_addr_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic              armed_o,
  output logic              triggered_o,
  output logic              done_o,
  output logic [AW-1:0]     trig_addr_o
);

  typedef enum logic [2:0] {S_IDLE, S_PRE, S_WAIT, S_POST, S_DONE} state_t;

  localparam logic [AW-1:0] L_PMAX     = AW'(DEPTH - 1);
  localparam logic [AW-1:0] L_POST_TOP = AW'(DEPTH - 2);

  state_t            r_state, w_next;
  logic [DATA_W-1:0] r_s, r_s_prev, r_mask, r_value, r_emask, r_rd_data;
  logic [AW-1:0]     r_p, r_wp, r_cnt, r_trig_addr;
  logic              r_trig_seen;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_arm, w_cap, w_we, w_trig, w_pre_last, w_post_last;
  logic [AW-1:0]     w_rd_idx;

  assign w_arm       = arm_i & ~abort_i;
  assign w_cap       = (r_state == S_PRE) | (r_state == S_WAIT) | (r_state == S_POST);
  assign w_we        = w_cap & ~abort_i & ~arm_i;
  assign w_trig      = force_trig_i |
                       (~|((r_s ^ r_value) & r_mask) &
                        (~|r_emask | (|((r_s ^ r_s_prev) & r_emask))));
  assign w_pre_last  = (r_cnt == r_p - AW'(1));
  // POST writes samples with r_cnt = 0 .. DEPTH-2-P, i.e. DEPTH-1-P of them.
  assign w_post_last = (r_cnt == L_POST_TOP - r_p);
  assign w_rd_idx    = r_trig_addr - r_p + rd_addr_i;

  // state register
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) r_state <= S_IDLE;
    else             r_state <= w_next;
  end

  // next-state
  always_comb begin
    w_next = r_state;
    if (abort_i)    w_next = S_IDLE;
    else if (arm_i) w_next = (pre_trig_i == '0) ? S_WAIT : S_PRE;
    else begin
      case (r_state)
        S_PRE:   if (w_pre_last)  w_next = S_WAIT;
        S_WAIT:  if (w_trig)      w_next = (r_p == L_PMAX) ? S_DONE : S_POST;
        S_POST:  if (w_post_last) w_next = S_DONE;
        default: w_next = r_state;
      endcase
    end
  end

  // outputs
  always_comb begin
    armed_o     = (r_state == S_PRE) | (r_state == S_WAIT);
    done_o      = (r_state == S_DONE);
    triggered_o = r_trig_seen;
    trig_addr_o = r_trig_addr;
    rd_data_o   = r_rd_data;
  end

  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn) begin
      r_s         <= '0;
      r_s_prev    <= '0;
      r_mask      <= '0;
      r_value     <= '0;
      r_emask     <= '0;
      r_p         <= '0;
      r_wp        <= '0;
      r_cnt       <= '0;
      r_trig_addr <= '0;
      r_trig_seen <= 1'b0;
    end else begin
      r_s      <= probe_i;
      r_s_prev <= r_s;
      if (w_arm) begin
        r_p         <= pre_trig_i;
        r_mask      <= trig_mask_i;
        r_value     <= trig_value_i;
        r_emask     <= edge_mask_i;
        r_wp        <= '0;
        r_cnt       <= '0;
        r_trig_seen <= 1'b0;
      end else if (w_we) begin
        r_wp <= r_wp + AW'(1);
        case (r_state)
          S_PRE:  r_cnt <= r_cnt + AW'(1);
          S_WAIT: if (w_trig) begin
            r_trig_addr <= r_wp;
            r_trig_seen <= 1'b1;
            r_cnt       <= '0;
          end
          S_POST: r_cnt <= r_cnt + AW'(1);
          default: r_cnt <= r_cnt;
        endcase
      end
    end
  end

  always_ff @(posedge sys_clk) begin
    if (w_we) r_mem[r_wp] <= r_s;
  end

  // Read register only updates in DONE so the output holds elsewhere.
  always_ff @(posedge sys_clk or negedge sys_resetn) begin
    if (!sys_resetn)             r_rd_data <= '0;
    else if (r_state == S_DONE)  r_rd_data <= r_mem[w_rd_idx];
  end

endmodule

// File: tb/tb_sdram_probe_capture.sv
// Directed bench for sdram_probe_capture at DEPTH=16, DATA_W=33.
module tb_sdram_probe_capture;

  localparam int DW = 33;
  localparam int DP = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] probe, mask, value, emask, rd_data;
  logic          arm, abort, force_trig, armed, triggered, done;
  logic [AW-1:0] pre, rd_addr, trig_addr;
  logic [31:0]   pc, hi_at;
  int            tests = 0, fails = 0;

  always #5 clk = ~clk;

  sdram_probe_capture #(.DATA_W(DW), .DEPTH(DP), .AW(AW)) dut (
    .sys_clk(clk), .sys_resetn(rst_n), .probe_i(probe), .arm_i(arm),
    .abort_i(abort), .force_trig_i(force_trig), .trig_mask_i(mask),
    .trig_value_i(value), .edge_mask_i(emask), .pre_trig_i(pre),
    .rd_addr_i(rd_addr), .rd_data_o(rd_data), .armed_o(armed),
    .triggered_o(triggered), .done_o(done), .trig_addr_o(trig_addr)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // probe = {bit32, counter}; bit32 goes high once the counter reaches hi_at
  task automatic set_probe(input logic [31:0] v);
    pc    = v;
    probe = {(pc >= hi_at), pc};
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    set_probe(pc + 32'd1);
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 200) begin
      tick();
      n++;
    end
    chk(tag, 64'(done), 64'd1);
  endtask

  task automatic rd_chk(input string tag, input int idx, input logic [DW-1:0] exp);
    rd_addr = AW'(idx);
    tick();
    chk(tag, 64'(rd_data), 64'(exp));
  endtask

  task automatic arm_at(input logic [31:0] p0);
    set_probe(p0);
    arm = 1'b1;
    tick();
    arm = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; arm = 0; abort = 0; force_trig = 0;
    mask = '0; value = '0; emask = '0; pre = '0; rd_addr = '0;
    hi_at = 32'hFFFF_FFFF;
    set_probe(32'd0);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_armed", 64'(armed), 64'd0);
    chk("rst_trig", 64'(triggered), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_taddr", 64'(trig_addr), 64'd0);
    chk("rst_rdata", 64'(rd_data), 64'd0);
    rst_n = 1'b1;
    tick();

    // level trigger on value 100, P=4
    pre = 4'd4; mask = '1; value = 33'd100; emask = '0;
    arm_at(32'd0);
    repeat (3) tick();
    chk("t1_armed", 64'(armed), 64'd1);
    chk("t1_trig0", 64'(triggered), 64'd0);
    wait_done("t1_done");
    chk("t1_trig", 64'(triggered), 64'd1);
    chk("t1_taddr", 64'(trig_addr), 64'd4);
    for (int i = 0; i < DP; i++) rd_chk($sformatf("t1_rd%0d", i), i, DW'(96 + i));

    // P=0, force one cycle after arm
    pre = 4'd0; value = 33'h1_FFFF_FFFF;
    arm_at(32'd200);
    chk("t2_armed", 64'(armed), 64'd1);
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    chk("t2_trig", 64'(triggered), 64'd1);
    chk("t2_taddr", 64'(trig_addr), 64'd0);
    repeat (14) tick();
    chk("t2_done14", 64'(done), 64'd0);
    tick();
    chk("t2_done15", 64'(done), 64'd1);
    rd_chk("t2_rd0", 0, 33'd200);
    rd_chk("t2_rd15", 15, 33'd215);

    // P=15, force ignored in PRE, level hit on first WAIT cycle
    pre = 4'd15; value = 33'd315;
    arm_at(32'd300);
    repeat (5) tick();
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    repeat (9) tick();
    chk("t3_armed", 64'(armed), 64'd1);
    chk("t3_trig0", 64'(triggered), 64'd0);
    chk("t3_done0", 64'(done), 64'd0);
    tick();
    chk("t3_done", 64'(done), 64'd1);
    chk("t3_trig", 64'(triggered), 64'd1);
    chk("t3_taddr", 64'(trig_addr), 64'd15);
    rd_chk("t3_rd15", 15, 33'd315);
    rd_chk("t3_rd0", 0, 33'd300);

    // edge trigger on bit32 rising at sample 40
    pre = 4'd0; mask = '0; value = '0; emask = 33'h1_0000_0000; hi_at = 32'd40;
    arm_at(32'd0);
    repeat (40) tick();
    chk("t4_trig0", 64'(triggered), 64'd0);
    chk("t4_armed", 64'(armed), 64'd1);
    tick();
    chk("t4_trig", 64'(triggered), 64'd1);
    chk("t4_taddr", 64'(trig_addr), 64'd8);
    wait_done("t4_done");
    rd_chk("t4_rd0", 0, 33'h1_0000_0028);
    rd_chk("t4_rd1", 1, 33'h1_0000_0029);
    hi_at = 32'hFFFF_FFFF;

    // abort in WAIT (with simultaneous arm), then a clean capture
    emask = '0; mask = '1; value = 33'h1_FFFF_FFFF; pre = 4'd0;
    arm_at(32'd500);
    repeat (3) tick();
    chk("t5_armed", 64'(armed), 64'd1);
    chk("t5_trigclr", 64'(triggered), 64'd0);
    abort = 1'b1; arm = 1'b1;
    tick();
    abort = 1'b0; arm = 1'b0;
    chk("t5_ab_armed", 64'(armed), 64'd0);
    chk("t5_ab_done", 64'(done), 64'd0);
    repeat (2) tick();
    chk("t5_idle", 64'(armed), 64'd0);
    pre = 4'd2; value = 33'd20;
    arm_at(32'd0);
    chk("t5_rearm", 64'(armed), 64'd1);
    wait_done("t5_done");
    chk("t5_trig", 64'(triggered), 64'd1);
    chk("t5_taddr", 64'(trig_addr), 64'd4);
    rd_chk("t5_rd0", 0, 33'd18);
    rd_chk("t5_rd2", 2, 33'd20);
    rd_chk("t5_rd15", 15, 33'd33);

    // reset while in POST
    pre = 4'd3; value = 33'h1_FFFF_FFFF;
    arm_at(32'd0);
    repeat (3) tick();
    force_trig = 1'b1;
    tick();
    force_trig = 1'b0;
    chk("t6_trig", 64'(triggered), 64'd1);
    chk("t6_taddr", 64'(trig_addr), 64'd3);
    tick();
    rst_n = 1'b0;
    #1;
    chk("t6_r_armed", 64'(armed), 64'd0);
    chk("t6_r_trig", 64'(triggered), 64'd0);
    chk("t6_r_done", 64'(done), 64'd0);
    chk("t6_r_taddr", 64'(trig_addr), 64'd0);
    chk("t6_r_rdata", 64'(rd_data), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (20) tick();
    chk("t6_post_armed", 64'(armed), 64'd0);
    chk("t6_post_done", 64'(done), 64'd0);
    chk("t6_post_trig", 64'(triggered), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
